// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter: round-robin arbiter sharing one memory port
// between the icache refill path and the dcache load/store path.
module ysyx_22040759_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ic_req_i,
    input  logic [ADDR_W-1:0]   ic_addr_i,
    output logic [DATA_W-1:0]   ic_rdata_o,
    output logic                ic_resp_valid_o,
    input  logic                dc_req_i,
    input  logic                dc_we_i,
    input  logic [ADDR_W-1:0]   dc_addr_i,
    input  logic [DATA_W-1:0]   dc_wdata_i,
    input  logic [DATA_W/8-1:0] dc_wstrb_i,
    output logic [DATA_W-1:0]   dc_rdata_o,
    output logic                dc_resp_valid_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ready_i,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    // owner/last bits: 1 = dcache, 0 = icache
    logic                  last_q, last_d, own_q, own_d;
    logic                  req_q, req_d, we_q, we_d, busy_q, busy_d;
    logic                  ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d, ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ic_rv_q <= 1'b0;
            dc_rv_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ic_rd_q <= '0;
            dc_rd_q <= '0;
        end else begin
            last_q  <= last_d;
            own_q   <= own_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ic_rv_q <= ic_rv_d;
            dc_rv_q <= dc_rv_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ic_rd_q <= ic_rd_d;
            dc_rd_q <= dc_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ic_rd_d = ic_rd_q;
        dc_rd_d = dc_rd_q;
        ic_rv_d = 1'b0;
        dc_rv_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ic_req_i || dc_req_i) begin
                    // dcache wins only when alone or when icache was granted last
                    own_d   = dc_req_i && (!ic_req_i || !last_q);
                    last_d  = own_d;
                    we_d    = own_d && dc_we_i;
                    addr_d  = own_d ? dc_addr_i : ic_addr_i;
                    wdata_d = own_d ? dc_wdata_i : '0;
                    wstrb_d = own_d ? dc_wstrb_i : '0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    ic_rd_d = own_q ? ic_rd_q : mem_rdata_i;
                    dc_rd_d = own_q ? mem_rdata_i : dc_rd_q;
                    ic_rv_d = !own_q;
                    dc_rv_d = own_q;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    assign mem_req_o       = req_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_wstrb_o     = wstrb_q;
    assign ic_rdata_o      = ic_rd_q;
    assign dc_rdata_o      = dc_rd_q;
    assign ic_resp_valid_o = ic_rv_q;
    assign dc_resp_valid_o = dc_rv_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// tb_ysyx_22040759_mem_arbiter: directed and randomized transactions checked
// against a transaction-level round-robin model.
module tb_ysyx_22040759_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [63:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata = '0;
    logic [7:0]  dc_wstrb = '0;
    logic        mem_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [63:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        ic_resp_valid, dc_resp_valid, mem_req, mem_we, busy;

    int          vectors = 0, errors = 0;
    bit          m_last_dc = 1'b1;
    logic [63:0] m_ic_rd = '0, m_dc_rd = '0;

    ysyx_22040759_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_rdata_o(ic_rdata),
        .ic_resp_valid_o(ic_resp_valid),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr),
        .dc_wdata_i(dc_wdata), .dc_wstrb_i(dc_wstrb), .dc_rdata_o(dc_rdata),
        .dc_resp_valid_o(dc_resp_valid),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_ready_i(mem_ready), .mem_resp_valid_i(mem_resp_valid),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
        chk({tag, "_ic_rdata"}, ic_rdata, 0);
        chk({tag, "_dc_rdata"}, dc_rdata, 0);
        chk({tag, "_resp_valid"}, {ic_resp_valid, dc_resp_valid}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction starting from an IDLE negedge; the expected
    // owner comes from the round-robin rule applied to the model's last grant.
    task automatic run_txn(input bit ic_en, input bit dc_en, input int stall, input int lat,
                           input bit drop, input bit poke, input logic [63:0] rdata);
        bit          own_dc;
        logic [63:0] e_addr;
        own_dc = dc_en && (!ic_en || !m_last_dc);
        e_addr = own_dc ? dc_addr : ic_addr;
        ic_req = ic_en;
        dc_req = dc_en;
        mem_ready = 1'b0;
        cyc();
        chk("grant_busy", busy, 1);
        chk("grant_mem_req", mem_req, 1);
        chk("grant_addr", mem_addr, e_addr);
        chk("grant_we", mem_we, own_dc && dc_we);
        chk("grant_wstrb", mem_wstrb, own_dc ? dc_wstrb : 8'h0);
        if (own_dc) chk("grant_wdata", mem_wdata, dc_wdata);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                dc_addr = {$urandom, $urandom};
                mem_resp_valid = (i == 0);
            end
            cyc();
            mem_resp_valid = 1'b0;
            chk("stall_mem_req", mem_req, 1);
            chk("stall_addr", mem_addr, e_addr);
            chk("stall_no_resp", {ic_resp_valid, dc_resp_valid}, 0);
        end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("wait_mem_req", mem_req, 0);
        chk("wait_busy", busy, 1);
        if (drop) begin
            if (own_dc) dc_req = 1'b0;
            else ic_req = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin
            cyc();
            chk("wait_no_resp", {ic_resp_valid, dc_resp_valid}, 0);
            chk("wait_busy2", busy, 1);
        end
        mem_resp_valid = 1'b1;
        mem_rdata = rdata;
        cyc();
        mem_resp_valid = 1'b0;
        if (own_dc) m_dc_rd = rdata;
        else m_ic_rd = rdata;
        chk("resp_ic_valid", ic_resp_valid, !own_dc);
        chk("resp_dc_valid", dc_resp_valid, own_dc);
        chk("resp_ic_rdata", ic_rdata, m_ic_rd);
        chk("resp_dc_rdata", dc_rdata, m_dc_rd);
        chk("resp_busy", busy, 1);
        if (own_dc) dc_req = 1'b0;
        else ic_req = 1'b0;
        m_last_dc = own_dc;
        cyc();
        chk("idle_resp_valid", {ic_resp_valid, dc_resp_valid}, 0);
        chk("idle_busy", busy, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        cyc();
        chk_zero("reset");
        rst_n = 1'b1;
        cyc();
        chk_zero("post_reset");

        ic_addr = 64'h8000_0010;
        run_txn(1, 0, 0, 1, 0, 0, 64'h1122_3344_5566_7788);

        dc_we = 1'b1; dc_addr = 64'h8000_1000; dc_wdata = 64'hDEAD_BEEF; dc_wstrb = 8'h0F;
        run_txn(0, 1, 2, 0, 0, 0, 64'h0);

        dc_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            ic_addr = {$urandom, $urandom} & ~64'h7;
            dc_addr = {$urandom, $urandom};
            run_txn(1, 1, 0, $urandom_range(0, 2), 0, 0, {$urandom, $urandom});
        end

        dc_addr = 64'h8000_2000;
        run_txn(0, 1, 5, 1, 0, 1, {$urandom, $urandom});

        ic_addr = 64'h8000_0040;
        run_txn(1, 0, 0, 2, 1, 0, {$urandom, $urandom});

        for (int t = 0; t < 24; t++) begin
            int r;
            r = $urandom_range(1, 3);
            ic_addr  = {$urandom, $urandom} & ~64'h7;
            dc_addr  = {$urandom, $urandom};
            dc_wdata = {$urandom, $urandom};
            dc_wstrb = 8'($urandom);
            dc_we    = 1'($urandom);
            run_txn(r[0], r[1], $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), {$urandom, $urandom});
        end

        // reset asserted between edges while waiting for the bridge
        ic_req = 1'b1; dc_req = 1'b1;
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        ic_req = 1'b0; dc_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_last_dc = 1'b1;
        m_ic_rd = '0;
        m_dc_rd = '0;
        cyc();
        chk_zero("after_rst");
        ic_addr = 64'h8000_0100; dc_addr = 64'h8000_3000; dc_we = 1'b0;
        run_txn(1, 1, 1, 1, 0, 0, {$urandom, $urandom});
        run_txn(1, 1, 0, 0, 0, 0, {$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
# ysyx_22040759_mem_arbiter

Two-requester arbiter and sequencer that shares the single memory port between the icache refill path and the dcache load/store path. It sits between the two caches and the AXI bridge. It grants one transaction at a time using round-robin, latches the command, and drives it to memory. It then waits for the memory response and returns it to the owning requester as a one-cycle pulse.

## Interface
Parameters:
- `ADDR_W`, 64, address width on all three sides.
- `DATA_W`, 64, data width; `wstrb` width is `DATA_W/8`.

Ports:
- `clk  input  1  clock`; one clock, all logic on the rising edge.
- `rst  input  1  reset`; asynchronous, active-low.
- `ic_req  input  1  icache refill request`; level, held until `ic_resp_valid`.
- `ic_addr  input  ADDR_W  icache refill address`; 8-byte aligned.
- `ic_rdata  output  DATA_W  refill data`; valid with `ic_resp_valid`.
- `ic_resp_valid  output  1  one-cycle completion pulse to the icache`.
- `dc_req  input  1  dcache request`; level, held until `dc_resp_valid`.
- `dc_we  input  1  dcache direction`; 1 = write, 0 = read.
- `dc_addr  input  ADDR_W  dcache address`.
- `dc_wdata  input  DATA_W  write data`.
- `dc_wstrb  input  DATA_W/8  byte strobes`.
- `dc_rdata  output  DATA_W  read data`; valid with `dc_resp_valid`.
- `dc_resp_valid  output  1  one-cycle completion pulse to the dcache`; pulses for both reads and writes.
- `mem_req  output  1  command valid to the memory bridge`.
- `mem_we  output  1  command direction`.
- `mem_addr  output  ADDR_W  command address`.
- `mem_wdata  output  DATA_W  command write data`.
- `mem_wstrb  output  DATA_W/8  command strobes`.
- `mem_ready  input  1  bridge accepts the command`; transfer occurs when `mem_req && mem_ready`.
- `mem_resp_valid  input  1  bridge completion`; one cycle.
- `mem_rdata  input  DATA_W  read data`; valid with `mem_resp_valid`.
- `busy  output  1  high in every state except IDLE`.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE
  - Samples `ic_req` and `dc_req`. The request inputs are ignored in every other state.
  - With a single requester, that requester is granted.
  - With both requesting, the requester not granted last wins.
  - The `last_grant` bit resets to dcache, so icache wins the first tie.
  - On grant, the command is latched into registers: the owner bit, plus we/addr/wdata/wstrb.
  - Icache commands always latch `we=0` and `wstrb=0`.
  - `last_grant` is updated to the owner, then the FSM moves to REQ.
- REQ
  - `mem_req=1` and `mem_*` are driven from the latched registers, stable until accepted.
  - When `mem_ready=1`, the FSM moves to WAIT.
- WAIT
  - `mem_req=0`.
  - When `mem_resp_valid=1`, `mem_rdata` is captured into the owner's rdata register and the FSM moves to RESP.
  - The non-owner's rdata is unchanged. A write response also overwrites `dc_rdata`, with don't-care content.
- RESP
  - The owner's `*_resp_valid` is 1 for exactly this cycle, then the FSM returns to IDLE.
  - The requester must drop or change its req in this cycle. IDLE on the next cycle sees only new requests.
- If a requester drops its req mid-transaction, the transaction still completes and its response still pulses.
- `mem_resp_valid` outside WAIT is a bridge protocol violation and is ignored.
- Reset values
  - State = IDLE; `last_grant` = dcache.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, both rdata, both resp_valid, `busy`.
- Reset mid-operation
  - The FSM returns to IDLE immediately, with outputs cleared asynchronously.
  - An in-flight memory transaction is abandoned; the bridge shares the same reset.

## Timing
- All outputs are registered; there are no combinational paths from any input to any output.
- Cycle 0: req high in IDLE.
- Cycle 1: `mem_req=1`, `busy=1`.
- `mem_ready` in cycle 1 gives WAIT in cycle 2. A `mem_resp_valid` in cycle 2 gives `*_resp_valid` in cycle 3, so minimum latency is 3 cycles.
- General latency: `*_resp_valid` is 1 cycle after the cycle `mem_resp_valid` is sampled in WAIT.
- Back-to-back:
  - The next grant is made in the IDLE cycle after RESP.
  - The next `mem_req` appears 2 cycles after the previous `resp_valid`.
  - Back-to-back throughput is therefore one transaction per (4 + bridge latency) cycles.
- rdata outputs hold their value until that requester's next response.

## Test plan
- Reset and single icache read
  - Stimulus: apply reset, then assert `ic_req` with `ic_addr=0x8000_0010`. The bridge has `mem_ready=1` and returns `mem_resp_valid` 2 cycles after accept with `mem_rdata=0x1122334455667788`.
  - Required: `mem_req` rises in cycle 1 with `mem_we=0`, `mem_wstrb=0`. `ic_resp_valid` pulses for one cycle with `ic_rdata=0x1122334455667788`. `dc_resp_valid` stays 0.
- Dcache write
  - Stimulus: `dc_req=1`, `dc_we=1`, `dc_addr=0x8000_1000`, `dc_wdata=0xDEADBEEF`, `dc_wstrb=0x0F`.
  - Required: the `mem_*` outputs carry exactly these values until `mem_ready`. `dc_resp_valid` pulses once.
- Simultaneous requests
  - Stimulus: after reset, `ic_req` and `dc_req` are both held high for two transactions each.
  - Required: grant order is ic, dc, ic, dc. Each `resp_valid` goes to the correct owner with the correct data.
- Stall on mem_ready
  - Stimulus: hold `mem_ready=0` for 5 cycles while in REQ, and change `dc_addr` meanwhile.
  - Required: `mem_req` stays 1 and `mem_addr` keeps the latched value. WAIT is entered only after `mem_ready`.
- Requester drop
  - Stimulus: `ic_req` falls while in WAIT.
  - Required: the response still produces an `ic_resp_valid` pulse, and no new icache grant is made.
- Reset mid-operation
  - Stimulus: assert `rst=0` asynchronously while in WAIT.
  - Required: all outputs are 0 before the next clock edge. After release, the first tie goes to icache.
